// File: rtl/score_sum_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module : score_sum_drain_pkg
// Brief  : Shared FSM encoding and node-id helper for the score-sum drain.
// Rev    : 1.0  initial release
// ============================================================================
package score_sum_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } drain_state_t;

    localparam int c_SKID_DEPTH = 2;

    // Global node id; callers truncate to their data width (wraps silently).
    function automatic logic [63:0] calc_node_id(input logic [31:0] bank,
                                                 input logic [31:0] idx,
                                                 input logic [31:0] nodes_per_bank);
        return 64'(bank) * 64'(nodes_per_bank) + 64'(idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_sum_drain_if.sv
`default_nettype none
// ============================================================================
// Module : score_sum_drain_if
// Brief  : Valid/ready stream of (node_id, score, last) toward the DMA.
// Rev    : 1.0  initial release
// ============================================================================
interface score_sum_drain_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_node;
    logic [DATA_WIDTH-1:0] out_score;
    logic                  out_last;

    modport master (output out_valid, out_node, out_score, out_last, input out_ready);
    modport slave  (input out_valid, out_node, out_score, out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/drain_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : drain_skid_buf
// Brief  : Two-entry valid/ready buffer with occupancy output.
// Rev    : 1.0  initial release
// ============================================================================
module drain_skid_buf
    import score_sum_drain_pkg::*;
#(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);
    localparam logic [1:0] c_FULL = 2'(c_SKID_DEPTH);

    logic [WIDTH-1:0] r_mem [c_SKID_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_cnt;
    assign w_pop   = o_valid & i_ready;
    assign w_push  = i_valid & ((r_cnt != c_FULL) | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/score_sum_drain.sv
`default_nettype none
// ============================================================================
// Module : score_sum_drain
// Brief  : Streams banked score sums out as (node, score) then zero-fills.
// Rev    : 1.0  initial release
// ============================================================================
module score_sum_drain
    import score_sum_drain_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 13,
    parameter int PARALLEL         = 16,
    parameter int node_num         = 5,
    parameter int last_node_num    = 5,
    parameter int CLEAR_AFTER_READ = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic [ADDR_WIDTH*PARALLEL-1:0] mem_addr_rd,
    input  logic [DATA_WIDTH*PARALLEL-1:0] mem_data_rd,
    output logic [PARALLEL-1:0]            mem_clr_en,
    output logic [DATA_WIDTH*PARALLEL-1:0] mem_data_clr,
    output logic                           busy,
    output logic                           done,
    score_sum_drain_if.master              m_out
);
    localparam int c_BANK_W = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;
    localparam int c_SKID_W = DATA_WIDTH * 2 + 1;
    localparam logic [c_BANK_W-1:0]   c_TOP_BANK  = c_BANK_W'(PARALLEL - 1);
    localparam logic [c_BANK_W-1:0]   c_LAST_BANK = c_BANK_W'((last_node_num == 0) ? PARALLEL - 2 : PARALLEL - 1);
    localparam logic [ADDR_WIDTH-1:0] c_NODE_END  = ADDR_WIDTH'(node_num - 1);
    localparam logic [ADDR_WIDTH-1:0] c_TOP_END   = ADDR_WIDTH'(last_node_num - 1);

    drain_state_t          r_state;
    drain_state_t          w_state_nxt;
    logic [c_BANK_W-1:0]   r_bank;
    logic [c_BANK_W-1:0]   r_rd_bank;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH-1:0] w_bank_end;
    logic                  r_rd_vld;
    logic                  r_rd_last;
    logic [DATA_WIDTH-1:0] r_rd_node;
    logic [DATA_WIDTH-1:0] w_issue_node;
    logic [DATA_WIDTH-1:0] w_rd_words [PARALLEL];
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_pop;
    logic                  w_skid_valid;
    logic [1:0]            w_skid_cnt;
    logic [2:0]            w_pending;
    logic [c_SKID_W-1:0]   w_skid_in;
    logic [c_SKID_W-1:0]   w_skid_out;

    // Occupancy net of this cycle's pop keeps 1 entry/cycle under full ready.
    assign w_pop        = w_skid_valid & m_out.out_ready;
    assign w_pending    = {1'b0, w_skid_cnt} - {2'b0, w_pop} + {2'b0, r_rd_vld};
    assign w_issue      = (r_state == ST_READ) && (w_pending < 3'd2);
    assign w_bank_end   = (r_bank == c_TOP_BANK) ? c_TOP_END : c_NODE_END;
    assign w_issue_last = (r_bank == c_LAST_BANK) && (r_index == w_bank_end);
    assign w_issue_node = DATA_WIDTH'(calc_node_id(32'(r_bank), 32'(r_index), 32'(node_num)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                busy = 1'b1;
                if (w_issue && w_issue_last) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if ((w_skid_cnt == 2'd0) && !r_rd_vld) begin
                    w_state_nxt = (CLEAR_AFTER_READ != 0) ? ST_CLEAR : ST_DONE;
                end
            end
            ST_CLEAR: begin
                busy = 1'b1;
                if (r_index == c_NODE_END) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank    <= '0;
            r_index   <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_bank <= '0;
            r_rd_node <= '0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_bank <= r_bank;
                r_rd_node <= w_issue_node;
                r_rd_last <= w_issue_last;
            end
            case (r_state)
                ST_READ: begin
                    if (w_issue) begin
                        if (r_index == w_bank_end) begin
                            r_index <= '0;
                            r_bank  <= r_bank + c_BANK_W'(1);
                        end else begin
                            r_index <= r_index + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_CLEAR: r_index <= r_index + ADDR_WIDTH'(1);
                default: begin
                    r_bank  <= '0;
                    r_index <= '0;
                end
            endcase
        end
    end

    for (genvar b = 0; b < PARALLEL; b++) begin : g_bank
        localparam int c_LIM = (b == PARALLEL - 1) ? last_node_num : node_num;
        assign w_rd_words[b] = mem_data_rd[b*DATA_WIDTH +: DATA_WIDTH];
        assign mem_addr_rd[b*ADDR_WIDTH +: ADDR_WIDTH] =
            ((r_state == ST_CLEAR) || ((r_state == ST_READ) && (r_bank == c_BANK_W'(b)))) ? r_index : '0;
        assign mem_clr_en[b] = (r_state == ST_CLEAR) && (r_index < ADDR_WIDTH'(c_LIM));
        assign mem_data_clr[b*DATA_WIDTH +: DATA_WIDTH] = '0;
    end

    assign w_skid_in = {r_rd_last, r_rd_node, w_rd_words[r_rd_bank]};

    drain_skid_buf #(
        .WIDTH (c_SKID_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_rd_vld),
        .i_data  (w_skid_in),
        .o_valid (w_skid_valid),
        .i_ready (m_out.out_ready),
        .o_data  (w_skid_out),
        .o_count (w_skid_cnt)
    );

    assign m_out.out_valid = w_skid_valid;
    assign m_out.out_last  = w_skid_out[c_SKID_W-1];
    assign m_out.out_node  = w_skid_out[DATA_WIDTH +: DATA_WIDTH];
    assign m_out.out_score = w_skid_out[DATA_WIDTH-1:0];
endmodule
`default_nettype wire
